irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt controller that shares the CPU's single `int0` line among several peripheral interrupt sources (UART receive-ready, timer, buttons). It latches rising edges per source into a pending register, applies an enable mask, picks one source, and holds `int0` with a source ID until the CPU acknowledges. It sits between the peripherals and `mips_cpu`, replacing the direct UART-to-`int0` wire in the peripheral top level.

## Interface
- `N_SRC`, 4: number of interrupt sources, at least 2.
- `ID_W`, `$clog2(N_SRC)`: width of the source ID.
- `MASK_RST`, all ones: reset value of the enable mask (bit = 1 means enabled).

- `clk`  in  1  single system clock, all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `src_irq`  in  N_SRC  per-source interrupt request, synchronous to `clk`, edge-significant.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  N_SRC  new mask value.
- `int_ack`  in  1  one-cycle CPU acknowledge, same handshake style as `uart_read_end`.
- `int0`  out  1  interrupt request to the CPU.
- `int_id`  out  ID_W  ID of the source being signalled; valid while `int0`=1.
- `pending`  out  N_SRC  raw pending bits, unmasked, for status reads.
- `mask`  out  N_SRC  current mask.

## Operation
- Edge detect: `src_q` holds the previous `src_irq`. `edge = src_irq & ~src_q`. Each edge bit sets `pending[i]`. Level-high without a new edge never re-sets it.
- Eligible set: `pending & mask`.
- FSM states:
  - IDLE: if eligible is non-zero, select a winner, latch `int_id`, go to ASSERT. Otherwise stay.
  - ASSERT: `int0`=1 and `int_id` is held stable. On `int_ack`, clear `pending[int_id]` and go to HOLDOFF.
  - HOLDOFF: `int0`=0 for one cycle, then go to IDLE.
- Selection without `IRQ_RR_EN`: fixed priority, lowest index wins.
- Same-cycle conflicts:
  - A new edge and an ack on the same source in the same cycle: set wins, so the pending bit stays 1.
  - Mask write and selection in the same cycle: selection uses the old mask.
- Masking:
  - Clearing a mask bit never clears its pending bit.
  - Masking the source already in ASSERT does not withdraw `int0`. It completes normally on ack.
- `int_ack` in IDLE or HOLDOFF is ignored, with no state or pending change.
- Reset (any time, including mid-ASSERT): `int0`=0, `int_id`=0, `pending`=0, `src_q`=0, `mask`=`MASK_RST`, state IDLE, round-robin pointer=0. A source held high through reset produces an edge on the first sampled cycle after release.

## Timing
- Edge sampled at clock edge k sets `pending` after edge k.
- If IDLE, `int0` rises after edge k+1. Latency is 2 clocks from `src_irq` first sampled high to `int0`.
- `int_ack` sampled at edge a: `int0` low after edge a, HOLDOFF during a+1, earliest re-assert after edge a+2. The minimum `int0` low gap is 2 cycles.
- `mask` updates after the edge that samples `mask_we`=1.
- All outputs are registered, with no combinational path from inputs to `int0`/`int_id`.

## Configuration
- `IRQ_RR_EN` defined: round-robin selection.
  - The pointer `rr_ptr` starts at 0.
  - Search starts at `rr_ptr` and wraps from N_SRC-1 to 0.
  - On ack, `rr_ptr` = `int_id`+1, wrapping to 0 past N_SRC-1.
- `IRQ_RR_EN` undefined: fixed priority, index 0 highest. No pointer register exists.

## Structure
- Package `irq_pkg` holds:
  - the state encoding constants `IRQ_IDLE`, `IRQ_ASSERT`, `IRQ_HOLDOFF` (2 bits);
  - the default `N_SRC`;
  - the ID-width function.
- Sub-module `irq_pick`: combinational picker taking eligible vector and start pointer, returning `found` and `id`. With the pointer tied to 0 it gives fixed priority. The top level instantiates it once.

## Test plan
- Reset, then pulse `src_irq[2]` one cycle → `pending`=4'b0100 next cycle, `int0`=1 with `int_id`=2 two cycles after the pulse. Ack → `int0`=0, `pending`=0.
- Pulse sources 1 and 3 together, fixed priority → `int_id`=1 first. After ack and 2-cycle gap, `int_id`=3.
- `IRQ_RR_EN`, keep sources 0 and 1 re-pulsing after each ack → IDs alternate 0,1,0,1.
- Write mask 4'b1110, pulse source 0 → `pending[0]`=1, no `int0`. Write mask 4'b1111 → `int0`=1 with `int_id`=0 two cycles later.
- In ASSERT with `int_id`=2, apply a new edge on source 2 in the ack cycle → `pending[2]` stays 1, `int0` re-asserts with `int_id`=2 after the gap.
- Drive `rst`=0 mid-ASSERT → `int0`, `pending`, `int_id` go to 0 immediately and `mask`=`MASK_RST`. An `int_ack` after release is ignored.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding, default source count and ID-width helper for irq_ctrl
package irq_pkg;
  localparam int IRQ_N_SRC = 4;
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_state_t;
  function automatic int irq_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/irq_pick.sv
// irq_pick: combinational picker, first eligible source searching upward from ptr with wrap
module irq_pick import irq_pkg::*; #(
  parameter int N_SRC = IRQ_N_SRC,
  parameter int ID_W  = irq_id_w(N_SRC)
) (
  input  logic [N_SRC-1:0] elig,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  id
);
  logic [N_SRC-1:0] rot;
  function automatic logic [ID_W-1:0] wrap(input logic [ID_W-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= N_SRC) s -= N_SRC;
    return ID_W'(s);
  endfunction
  assign rot   = N_SRC'({elig, elig} >> ptr);
  assign found = |rot;
  // walk from the far end so the closest set bit to ptr is written last and wins
  always_comb begin
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (rot[i]) id = wrap(ptr, i);
  end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: shares int0 among N_SRC edge-triggered sources; IRQ_RR_EN selects round-robin instead of fixed priority
module irq_ctrl import irq_pkg::*; #(
  parameter int               N_SRC    = IRQ_N_SRC,
  parameter int               ID_W     = irq_id_w(N_SRC),
  parameter logic [N_SRC-1:0] MASK_RST = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             int_ack,
  output logic             int0,
  output logic [ID_W-1:0]  int_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);
  irq_state_t       state, state_n;
  logic [N_SRC-1:0] src_q, rise, clr;
  logic [ID_W-1:0]  ptr, pick_id;
  logic             found, ack_hit;
  assign rise    = src_irq & ~src_q;
  assign ack_hit = (state == IRQ_ASSERT) && int_ack;
  assign clr     = {{(N_SRC-1){1'b0}}, ack_hit} << int_id;
  assign int0    = (state == IRQ_ASSERT);
  irq_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
    .elig  (pending & mask),
    .ptr   (ptr),
    .found (found),
    .id    (pick_id)
  );
`ifdef IRQ_RR_EN
  logic [ID_W-1:0] rr_ptr;
  // after each ack the search restarts just past the source that was served
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr_ptr <= '0;
    else if (ack_hit) rr_ptr <= (int_id == ID_W'(N_SRC - 1)) ? '0 : int_id + 1'b1;
  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif
  // edge history, pending (new edge beats ack clear), mask and latched winner
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= MASK_RST;
      int_id  <= '0;
    end else begin
      src_q   <= src_irq;
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      if (state == IRQ_IDLE && found) int_id <= pick_id;
    end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IRQ_IDLE;
    else state <= state_n;
  // IDLE -> ASSERT on any eligible source, ASSERT -> HOLDOFF on ack, HOLDOFF -> IDLE
  always_comb begin
    state_n = IRQ_IDLE;
    state_n = (state == IRQ_ASSERT) ? (int_ack ? IRQ_HOLDOFF : IRQ_ASSERT) :
              (state == IRQ_IDLE && found) ? IRQ_ASSERT : IRQ_IDLE;
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] src_irq = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       int_ack = 1'b0;
  logic       int0;
  logic [1:0] int_id;
  logic [3:0] pending;
  logic [3:0] mask;
  int checks = 0;
  int errors = 0;

  irq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .int0       (int0),
    .int_id     (int_id),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL reset_int0 got %b want 0", int0); end
    checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", int_id); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending); end
    checks++; if (mask !== 4'hF) begin errors++; $display("FAIL reset_mask got %h want f", mask); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    src_irq = 4'b0100;
    step();
    src_irq = 4'b0000;
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending got %b want 0100", pending); end
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", int0); end
    step();
    checks++; if (int0 !== 1'b1) begin errors++; $display("FAIL single_int0 got %b want 1", int0); end
    checks++; if (int_id !== 2'd2) begin errors++; $display("FAIL single_id got %0d want 2", int_id); end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL single_ack_int0 got %b want 0", int0); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_ack_pending got %b want 0000", pending); end
    step();
  endtask

  task automatic test_priority();
    src_irq = 4'b1010;
    step();
    src_irq = 4'b0000;
    step();
    checks++; if (int0 !== 1'b1 || int_id !== 2'd1) begin errors++; $display("FAIL prio_first got int0=%b id=%0d want 1/1", int0, int_id); end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_pending got %b want 1000", pending); end
    step();
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL prio_gap got %b want 0", int0); end
    step();
    checks++; if (int0 !== 1'b1 || int_id !== 2'd3) begin errors++; $display("FAIL prio_second got int0=%b id=%0d want 1/3", int0, int_id); end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_drain got %b want 0000", pending); end
    step();
  endtask

  task automatic test_mask();
    mask_we = 1'b1;
    mask_wdata = 4'b1110;
    src_irq = 4'b0001;
    step();
    mask_we = 1'b0;
    src_irq = 4'b0000;
    checks++; if (mask !== 4'b1110) begin errors++; $display("FAIL mask_write got %b want 1110", mask); end
    step();
    step();
    checks++; if (int0 !== 1'b0 || pending !== 4'b0001) begin errors++; $display("FAIL mask_blocked got int0=%b pend=%b want 0/0001", int0, pending); end
    mask_we = 1'b1;
    mask_wdata = 4'b1111;
    step();
    mask_we = 1'b0;
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL mask_old_used got %b want 0", int0); end
    step();
    checks++; if (int0 !== 1'b1 || int_id !== 2'd0) begin errors++; $display("FAIL mask_release got int0=%b id=%0d want 1/0", int0, int_id); end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    step();
  endtask

  task automatic test_ack_reedge();
    src_irq = 4'b0100;
    step();
    src_irq = 4'b0000;
    step();
    int_ack = 1'b1;
    src_irq = 4'b0100;
    step();
    int_ack = 1'b0;
    src_irq = 4'b0000;
    checks++; if (pending !== 4'b0100 || int0 !== 1'b0) begin errors++; $display("FAIL reedge_set_wins got pend=%b int0=%b want 0100/0", pending, int0); end
    step();
    checks++; if (int0 !== 1'b0) begin errors++; $display("FAIL reedge_gap got %b want 0", int0); end
    step();
    checks++; if (int0 !== 1'b1 || int_id !== 2'd2) begin errors++; $display("FAIL reedge_again got int0=%b id=%0d want 1/2", int0, int_id); end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    step();
  endtask

  task automatic test_idle_ack_and_mask_in_assert();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    checks++; if (int0 !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL idle_ack got int0=%b pend=%b want 0/0000", int0, pending); end
    src_irq = 4'b0010;
    step();
    src_irq = 4'b0000;
    step();
    mask_we = 1'b1;
    mask_wdata = 4'b0000;
    step();
    mask_we = 1'b0;
    checks++; if (int0 !== 1'b1 || int_id !== 2'd1 || mask !== 4'b0000) begin errors++; $display("FAIL mask_in_assert got int0=%b id=%0d mask=%b want 1/1/0000", int0, int_id, mask); end
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    checks++; if (int0 !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL mask_in_assert_ack got int0=%b pend=%b want 0/0000", int0, pending); end
    mask_we = 1'b1;
    mask_wdata = 4'b1111;
    step();
    mask_we = 1'b0;
  endtask

`ifdef IRQ_RR_EN
  task automatic test_rr();
    src_irq = 4'b0011;
    step();
    src_irq = 4'b0000;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (int0 !== 1'b1 || int_id !== 2'(k % 2)) begin errors++; $display("FAIL rr_%0d got int0=%b id=%0d want 1/%0d", k, int0, int_id, k % 2); end
      int_ack = 1'b1;
      src_irq = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      step();
      int_ack = 1'b0;
      src_irq = 4'b0000;
      step();
      step();
    end
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
  endtask
`endif

  task automatic test_reset_mid();
    mask_we = 1'b1;
    mask_wdata = 4'b1011;
    src_irq = 4'b1000;
    step();
    mask_we = 1'b0;
    src_irq = 4'b0000;
    step();
    checks++; if (int0 !== 1'b1 || int_id !== 2'd3) begin errors++; $display("FAIL mid_setup got int0=%b id=%0d want 1/3", int0, int_id); end
    rst = 1'b0;
    #1;
    checks++; if (int0 !== 1'b0 || int_id !== 2'd0 || pending !== 4'b0000 || mask !== 4'hF) begin errors++; $display("FAIL mid_reset got int0=%b id=%0d pend=%b mask=%b want 0/0/0000/1111", int0, int_id, pending, mask); end
    step();
    rst = 1'b1;
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    checks++; if (int0 !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL post_reset_ack got int0=%b pend=%b want 0/0000", int0, pending); end
    rst = 1'b0;
    src_irq = 4'b0001;
    step();
    rst = 1'b1;
    step();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL held_high_edge got %b want 0001", pending); end
    step();
    checks++; if (int0 !== 1'b1 || int_id !== 2'd0) begin errors++; $display("FAIL held_high_int0 got int0=%b id=%0d want 1/0", int0, int_id); end
    src_irq = 4'b0000;
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL held_high_ack got %b want 0000", pending); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_ack_reedge();
    test_idle_ack_and_mask_in_assert();
`ifdef IRQ_RR_EN
    test_rr();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
